// File: rtl/mod_serializer.sv
// mod_serializer: width-down converter. Accepts one packed word of
// LANES x WIDTH bits over a valid/ready handshake and emits it one lane
// per beat over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    packed input word, lane k = in_data[k]
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle
//   out_data   current lane
//   out_valid  out_data is valid
//   out_ready  consumer takes out_data this cycle
//   out_last   high with the final lane of a word
//   busy       a word is held (same as out_valid)
module mod_serializer #(
   parameter int WIDTH     = 8,
   parameter int LANES     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LANES-1:0][WIDTH-1:0]  in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] FIRST = MSB_FIRST ? IW'(LANES-1) : IW'(0);
   localparam logic [IW-1:0] LAST  = MSB_FIRST ? IW'(0) : IW'(LANES-1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t                      state, state_nxt;
   logic [IW-1:0]               idx;
   logic [LANES-1:0][WIDTH-1:0] hold;
   logic                        beat, accept;

   assign beat   = out_valid && out_ready;
   assign accept = in_valid && in_ready;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (beat && out_last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs; in_ready opens on the final accepted beat so the next word
   // loads in the same edge with no bubble
   always_comb begin
      out_valid = (state == SHIFT);
      out_last  = out_valid && (idx == LAST);
      busy      = out_valid;
      in_ready  = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));
      out_data  = '0;
      for (int k = 0; k < LANES; k++)
         if (idx == IW'(k)) out_data = hold[k];
   end

   // holding register and lane index. idx is left alone when the word
   // finishes so out_data keeps showing the last lane while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
         idx  <= '0;
      end else if (accept) begin
         hold <= in_data;
         idx  <= FIRST;
      end else if (beat && !out_last) begin
         idx  <= MSB_FIRST ? idx - IW'(1) : idx + IW'(1);
      end
   end

endmodule
